// File: rtl/seg_gray_pkg.sv
// Shared constants and helpers for the seven-segment decimal-Gray receiver.
// Segment bit order is a..g on bits 6..0, 1 = lit.
package seg_gray_pkg;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

  // The tens digit only ever shows blank (0) or a one.
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_ONE   = 7'b0110000;

  localparam int G_W = 4;

  function automatic logic [G_W-1:0] gray_to_bin(input logic [G_W-1:0] g);
    logic [G_W-1:0] b;
    b[G_W-1] = g[G_W-1];
    for (int i = G_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/seg_gray_receiver_if.sv
// Input/output handshake bundle for seg_gray_receiver.
// Valid/ready: a word moves when valid && ready at a rising edge; ready never depends on valid.
interface seg_gray_receiver_if;
  logic [6:0] seg_tens;
  logic [6:0] seg_units;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_bin;
  logic       out_err;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output seg_tens, seg_units, in_valid, out_ready,
    input  in_ready, out_bin, out_err, out_valid
  );

  modport slave (
    input  seg_tens, seg_units, in_valid, out_ready,
    output in_ready, out_bin, out_err, out_valid
  );
endinterface

// File: rtl/seg7_digit_decode.sv
// Seven-segment pattern to digit lookup. With tens_mode set only blank/one
// are legal; otherwise the ten units glyphs are recognised.
module seg7_digit_decode
  import seg_gray_pkg::*;
#(
  parameter bit tens_mode = 1'b0
) (
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       illegal
);

  always_comb begin
    digit   = 4'd0;
    illegal = 1'b0;
    if (tens_mode) begin
      case (pattern)
        SEG_BLANK: digit = 4'd0;
        SEG_ONE:   digit = 4'd1;
        default:   illegal = 1'b1;
      endcase
    end else begin
      case (pattern)
        SEG_0:   digit = 4'd0;
        SEG_1:   digit = 4'd1;
        SEG_2:   digit = 4'd2;
        SEG_3:   digit = 4'd3;
        SEG_4:   digit = 4'd4;
        SEG_5:   digit = 4'd5;
        SEG_6:   digit = 4'd6;
        SEG_7:   digit = 4'd7;
        SEG_8:   digit = 4'd8;
        SEG_9:   digit = 4'd9;
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/seg_gray_receiver.sv
// Two-stage valid/ready pipeline turning a two-digit seven-segment decimal Gray code
// into binary. Define SEG_GRAY_ERR_CNT_EN to add the saturating err_cnt output.
module seg_gray_receiver
  import seg_gray_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  seg_gray_receiver_if.slave  bus
`ifdef SEG_GRAY_ERR_CNT_EN
  ,
  output logic [7:0]          err_cnt
`endif
);

  logic [3:0] tens_dig;
  logic [3:0] units_dig;
  logic       tens_ill;
  logic       units_ill;
  logic [7:0] g_full;
  logic       dec_err;

  logic       s1_valid;
  logic [3:0] s1_g;
  logic       s1_err;

  logic       out_valid_q;
  logic [3:0] out_bin_q;
  logic       out_err_q;

  logic       s2_load;
  logic       s1_load;

  seg7_digit_decode #(.tens_mode(1'b1)) u_tens (
    .pattern (bus.seg_tens),
    .digit   (tens_dig),
    .illegal (tens_ill)
  );

  seg7_digit_decode #(.tens_mode(1'b0)) u_units (
    .pattern (bus.seg_units),
    .digit   (units_dig),
    .illegal (units_ill)
  );

  // Values above 15 do not fit the 4-bit Gray space and count as illegal.
  assign g_full  = 8'(tens_dig) * 8'd10 + 8'(units_dig);
  assign dec_err = tens_ill | units_ill | (g_full > 8'd15);

  assign s2_load = !out_valid_q || bus.out_ready;
  assign s1_load = !s1_valid || s2_load;

  assign bus.in_ready  = s1_load;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bin   = out_bin_q;
  assign bus.out_err   = out_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_g     <= 4'd0;
      s1_err   <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_g   <= g_full[3:0];
        s1_err <= dec_err;
      end
    end
  end

  // Illegal words still travel as ordinary outputs, with the value forced to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_bin_q   <= 4'd0;
      out_err_q   <= 1'b0;
    end else if (s2_load) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        out_bin_q <= s1_err ? 4'd0 : gray_to_bin(s1_g);
        out_err_q <= s1_err;
      end
    end
  end

`ifdef SEG_GRAY_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (out_valid_q && bus.out_ready && out_err_q && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seg_gray_receiver.sv
// Randomised and directed bench for seg_gray_receiver against a queue-based reference model.
// Honours SEG_GRAY_ERR_CNT_EN to also check the error counter.
module tb_seg_gray_receiver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  seg_gray_receiver_if bus();

`ifdef SEG_GRAY_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  seg_gray_receiver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SEG_GRAY_ERR_CNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [6:0] unit_pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
  localparam logic [6:0] T_BLANK = 7'b0000000;
  localparam logic [6:0] T_ONE   = 7'b0110000;

  int n_cmp = 0;
  int n_bad = 0;
  logic [4:0] exp_q[$];
  int acc_cnt = 0;
  int pop_cnt = 0;
  int err_exp = 0;
  logic [3:0] last_bin;
  logic       last_err;
  logic       held_v = 1'b0;
  logic [4:0] held_w;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: {err, bin} straight from the digit tables and decimal Gray rules.
  function automatic logic [4:0] model_word(input logic [6:0] t, input logic [6:0] u);
    int td = -1;
    int ud = -1;
    int g;
    int b;
    if (t == T_BLANK) td = 0;
    else if (t == T_ONE) td = 1;
    for (int i = 0; i < 10; i++) if (u == unit_pat[i]) ud = i;
    if (td < 0 || ud < 0) return 5'b10000;
    g = 10 * td + ud;
    if (g > 15) return 5'b10000;
    b = g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    return {1'b0, 4'(b)};
  endfunction

  // Monitor: everything seen at the negedge is what the next posedge will act on.
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      check("in_ready", int'(bus.in_ready), int'(exp_q.size() < 2 || bus.out_ready));
      if (exp_q.size() == 2) check("full_valid", int'(bus.out_valid), 1);
      if (exp_q.size() == 0) check("empty_valid", int'(bus.out_valid), 0);
      if (held_v) begin
        check("hold_valid", int'(bus.out_valid), 1);
        check("hold_word", int'({bus.out_err, bus.out_bin}), int'(held_w));
      end
`ifdef SEG_GRAY_ERR_CNT_EN
      check("err_cnt", int'(err_cnt), err_exp);
`endif
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("pop_empty", 1, 0);
        end else begin
          check("out_word", int'({bus.out_err, bus.out_bin}), int'(exp_q.pop_front()));
        end
        last_bin = bus.out_bin;
        last_err = bus.out_err;
        pop_cnt++;
        if (bus.out_err && err_exp < 255) err_exp++;
      end
      held_v = bus.out_valid && !bus.out_ready;
      held_w = {bus.out_err, bus.out_bin};
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model_word(bus.seg_tens, bus.seg_units));
        acc_cnt++;
      end
    end
  end

  // Called just after a posedge; returns just after the posedge that accepted the word.
  task automatic send(input logic [6:0] t, input logic [6:0] u);
    int n = 0;
    bus.seg_tens  = t;
    bus.seg_units = u;
    bus.in_valid  = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 || bus.out_valid) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 100) begin
        check("drain_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_g(input int g);
    send((g >= 10) ? T_ONE : T_BLANK, unit_pat[g % 10]);
  endtask

  initial begin
    int a0;
    int p0;
    bus.seg_tens  = 7'd0;
    bus.seg_units = 7'd0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    // Pin the model with hand-computed values.
    check("model_g0", int'(model_word(T_BLANK, 7'b1111110)), 0);
    check("model_g15", int'(model_word(T_ONE, 7'b1011011)), 10);
    check("model_g8", int'(model_word(T_BLANK, 7'b1111111)), 15);
    check("model_g18", int'(model_word(T_ONE, 7'b1111111)), 16);

    #1;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_bin", int'(bus.out_bin), 0);
    check("rst_out_err", int'(bus.out_err), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Latency of 2: valid is absent one cycle after accept, present the next.
    send(T_BLANK, 7'b1111110);
    check("lat_cycle1_valid", int'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    check("lat_cycle2_valid", int'(bus.out_valid), 1);
    check("g0_bin", int'(bus.out_bin), 0);
    check("g0_err", int'(bus.out_err), 0);
    drain();

    send(T_ONE, 7'b1011011);
    drain();
    check("g15_bin", int'(last_bin), 10);
    send(T_BLANK, 7'b1111111);
    drain();
    check("g8_bin", int'(last_bin), 15);

    send(T_ONE, 7'b1111111);
    drain();
    check("g18_err", int'(last_err), 1);
    check("g18_bin", int'(last_bin), 0);
    send(7'b1000000, 7'b1111110);
    drain();
    check("bad_tens_err", int'(last_err), 1);
`ifdef SEG_GRAY_ERR_CNT_EN
    check("err_cnt_two", int'(err_cnt), 2);
`endif

    // Backpressure: 16-word stream with the consumer stalled for 5 cycles.
    a0 = acc_cnt;
    p0 = pop_cnt;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int g = 0; g < 16; g++) send_g(g);
      end
      begin
        repeat (5) @(negedge clk);
        #1;
        check("stall_accepts", acc_cnt - a0, 2);
        check("stall_in_ready", int'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("stream_pops", pop_cnt - p0, 16);

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       bus.seg_tens = T_ONE;
        1:       bus.seg_tens = 7'($urandom);
        default: bus.seg_tens = T_BLANK;
      endcase
      bus.seg_units = ($urandom_range(0, 4) == 0) ? 7'($urandom) : unit_pat[$urandom_range(0, 9)];
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    drain();

    // Reset between edges with both stages full.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.seg_tens  = T_BLANK;
    bus.seg_units = unit_pat[3];
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_in_ready", int'(bus.in_ready), 1);
    check("midrst_out_err", int'(bus.out_err), 0);
    exp_q.delete();
    err_exp = 0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end

`ifdef SEG_GRAY_ERR_CNT_EN
    a0 = acc_cnt;
    bus.seg_tens  = 7'b1000000;
    bus.seg_units = unit_pat[0];
    bus.in_valid  = 1'b1;
    for (int c = 0; c < 2000 && (acc_cnt - a0) < 300; c++) begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    drain();
    check("err_cnt_sat", int'(err_cnt), 255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
